// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive stage: sync, start detect, mid-bit sampling, stop check
module uart_receiver #(
   parameter int BAUD_RATE         = 10000,
   parameter int CLOCK_FREQUENCY   = 250000000,
   parameter int CYCLES_PER_SAMPLE = CLOCK_FREQUENCY / BAUD_RATE,
   parameter int HALF_SAMPLE       = CYCLES_PER_SAMPLE / 2
) (
   input  logic       clk,
   input  logic       r_reset,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_error,
   output logic       o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   localparam logic [15:0] BIT_LAST  = 16'(CYCLES_PER_SAMPLE - 1);
   localparam logic [15:0] HALF_LAST = 16'(HALF_SAMPLE - 1);

   state_t      state_q, state_d;
   logic        sync1_q, sync2_q, sync3_q;
   logic        fill_q;
   logic        armed_q, armed_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;

   always_ff @(posedge clk) begin
      if (r_reset) begin
         state_q   <= S_IDLE;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         sync3_q   <= 1'b1;
         fill_q    <= 1'b0;
         armed_q   <= 1'b0;
         cnt_q     <= 16'd0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
         data_q    <= 8'd0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= i_rx;
         sync2_q   <= sync1_q;
         sync3_q   <= sync2_q;
         fill_q    <= 1'b1;
         armed_q   <= armed_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 16'd1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      // Start detection stays disarmed until the real line has been seen high,
      // so a line low through and after reset never fakes a falling edge.
      armed_d   = armed_q | (fill_q & sync1_q);
      case (state_q)
         S_IDLE: begin
            if (armed_q && !sync2_q && sync3_q) begin
               state_d = S_START;
               cnt_d   = 16'd0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = 16'd0;
               if (!sync2_q) begin
                  state_d   = S_DATA;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d              = 16'd0;
               shift_d[bit_idx_q] = sync2_q;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = 16'd0;
               state_d = S_IDLE;
               if (sync2_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_data        = data_q;
   assign o_valid       = valid_q;
   assign o_frame_error = ferr_q;
   assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed-vector bench for uart_receiver at 16 cycles per bit
module tb_uart_receiver;

   localparam int BIT  = 16;
   localparam int HMAX = 8192;

   logic       clk = 1'b0;
   logic       r_reset = 1'b1;
   logic       i_rx = 1'b1;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_error;
   logic       o_busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic       valid_hist [HMAX];
   logic       ferr_hist  [HMAX];
   logic       busy_hist  [HMAX];
   logic [7:0] data_hist  [HMAX];

   uart_receiver #(
      .BAUD_RATE(10),
      .CLOCK_FREQUENCY(160)
   ) dut (
      .clk(clk),
      .r_reset(r_reset),
      .i_rx(i_rx),
      .o_data(o_data),
      .o_valid(o_valid),
      .o_frame_error(o_frame_error),
      .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < HMAX) begin
         valid_hist[cyc] = o_valid;
         ferr_hist[cyc]  = o_frame_error;
         busy_hist[cyc]  = o_busy;
         data_hist[cyc]  = o_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // kind: 0 valid, 1 frame error, 2 busy; counts high samples in [a, b]
   function automatic int count_hist(input int kind, input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) begin
         if (i >= 0 && i < HMAX) begin
            if (kind == 0 && valid_hist[i] === 1'b1) n++;
            if (kind == 1 && ferr_hist[i]  === 1'b1) n++;
            if (kind == 2 && busy_hist[i]  === 1'b1) n++;
         end
      end
      return n;
   endfunction

   // Entered and left at posedge+#1; holds the level for BIT posedges.
   task automatic drive_bit(input logic b);
      i_rx = b;
      repeat (BIT) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      i_rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, output int e0);
      e0 = cyc + 1;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
   endtask

   int e0, e1, t0;

   initial begin
      // reset state
      repeat (5) @(posedge clk);
      #1;
      r_reset = 1'b0;
      check("rst_valid", o_valid, 0);
      check("rst_ferr", o_frame_error, 0);
      check("rst_busy", o_busy, 0);
      check("rst_data", o_data, 8'h00);
      idle(20);

      // single frame 0xA5
      send_frame(8'hA5, 1'b1, e0);
      idle(10);
      check("a5_busy_before", busy_hist[e0+1], 0);
      check("a5_busy_start", busy_hist[e0+2], 1);
      check("a5_busy_last", busy_hist[e0+153], 1);
      check("a5_busy_after", busy_hist[e0+154], 0);
      check("a5_valid_at_154", valid_hist[e0+154], 1);
      check("a5_valid_count", count_hist(0, e0, cyc - 1), 1);
      check("a5_ferr_count", count_hist(1, e0, cyc - 1), 0);
      check("a5_data", data_hist[e0+154], 8'hA5);

      // back-to-back 0x00, 0xFF
      send_frame(8'h00, 1'b1, e0);
      send_frame(8'hFF, 1'b1, e1);
      idle(10);
      check("b2b_spacing", e1 - e0, 160);
      check("b2b_valid0", valid_hist[e0+154], 1);
      check("b2b_data0", data_hist[e0+154], 8'h00);
      check("b2b_valid1", valid_hist[e0+314], 1);
      check("b2b_data1", data_hist[e0+314], 8'hFF);
      check("b2b_valid_count", count_hist(0, e0, cyc - 1), 2);
      check("b2b_ferr_count", count_hist(1, e0, cyc - 1), 0);

      // 0x3C with low stop bit
      send_frame(8'h3C, 1'b0, e0);
      idle(20);
      check("fe_pulse_at_154", ferr_hist[e0+154], 1);
      check("fe_count", count_hist(1, e0, cyc - 1), 1);
      check("fe_valid_count", count_hist(0, e0, cyc - 1), 0);
      check("fe_data_held", o_data, 8'hFF);

      // 4-cycle glitch then 0x55
      e0 = cyc + 1;
      i_rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      idle(30);
      check("gl_busy_start", busy_hist[e0+2], 1);
      check("gl_busy_mid", busy_hist[e0+9], 1);
      check("gl_idle_at_10", busy_hist[e0+10], 0);
      check("gl_valid_count", count_hist(0, e0, cyc - 1), 0);
      check("gl_ferr_count", count_hist(1, e0, cyc - 1), 0);
      send_frame(8'h55, 1'b1, e0);
      idle(10);
      check("gl_55_valid", valid_hist[e0+154], 1);
      check("gl_55_data", data_hist[e0+154], 8'h55);

      // reset during data bit 3 of 0x81
      t0 = cyc + 1;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      i_rx = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      r_reset = 1'b1;
      @(posedge clk);
      #1;
      r_reset = 1'b0;
      check("rm_busy_after_rst", o_busy, 0);
      check("rm_data_after_rst", o_data, 8'h00);
      repeat (7) @(posedge clk);
      #1;
      for (int i = 4; i < 7; i++) drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      idle(20);
      check("rm_valid_count", count_hist(0, t0, cyc - 1), 0);
      check("rm_ferr_count", count_hist(1, t0, cyc - 1), 0);
      send_frame(8'h81, 1'b1, e0);
      idle(10);
      check("rm_81_valid", valid_hist[e0+154], 1);
      check("rm_81_data", data_hist[e0+154], 8'h81);

      // line held low across reset, then released
      t0 = cyc + 1;
      i_rx = 1'b0;
      r_reset = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      r_reset = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      idle(60);
      check("lo_valid_count", count_hist(0, t0, cyc - 1), 0);
      check("lo_ferr_count", count_hist(1, t0, cyc - 1), 0);
      check("lo_busy_count", count_hist(2, t0, cyc - 1), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
